// File: rtl/ysyx_25030081_mem_pkg.sv
// Shared definitions for the data-memory responder.
//   mem_state_t : responder FSM encoding (IDLE / BUSY / RESP)
//   MASK_W      : number of byte lanes in a 32-bit word
//   LFSR_SEED   : reset value of the random-delay LFSR
//   LFSR_TAPS   : feedback taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
package ysyx_25030081_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } mem_state_t;

    localparam int         MASK_W    = 4;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/ysyx_25030081_lfsr8.sv
// 8-bit Fibonacci LFSR used to jitter the responder latency.
// Only instantiated when YSYX_25030081_SRAM_RAND_DELAY_EN is defined.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset, loads LFSR_SEED
//   en    : advance one step this cycle
//   state : current LFSR value
module ysyx_25030081_lfsr8
    import ysyx_25030081_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] state
);

    logic fb;

    assign fb = ^(state & LFSR_TAPS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LFSR_SEED;
        end else if (en) begin
            state <= {state[6:0], fb};
        end
    end

endmodule

// File: rtl/ysyx_25030081_sram_resp.sv
// Timed data-memory responder: target end of the LSU memory interface.
// One word-aligned read or write per transaction; the access happens on an
// internal word array a fixed number of cycles after the request handshake,
// and the result is offered on a valid/ready response channel.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only while idle)
//   req_wen               : 1 = write, 0 = read
//   req_addr              : byte address
//   req_wdata/req_wmask   : lane-aligned write data and byte enables
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata             : read word (0 for writes and errors)
//   rsp_err               : misaligned or out-of-range address
// Optional: define YSYX_25030081_SRAM_RAND_DELAY_EN to add 0..7 cycles of
// pseudo-random latency per request.
module ysyx_25030081_sram_resp
    import ysyx_25030081_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [MASK_W-1:0]     req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Wide enough for LATENCY (max 15) plus up to 7 cycles of jitter.
    localparam int CNT_W = 5;

    mem_state_t            state_q;
    mem_state_t            state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_load;

    logic                  lat_wen;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [MASK_W-1:0]     lat_wmask;

    logic                  req_fire;
    logic                  access;
    logic                  addr_err;
    logic [IDX_W-1:0]      word_idx;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign req_fire = req_valid && req_ready;
    // The array is touched exactly once, in the last BUSY cycle.
    assign access   = (state_q == ST_BUSY) && (cnt_q == CNT_W'(1));
    assign addr_err = (lat_addr[1:0] != 2'b00) ||
                      (lat_addr[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(DEPTH));
    assign word_idx = lat_addr[IDX_W+1:2];

`ifdef YSYX_25030081_SRAM_RAND_DELAY_EN
    logic [7:0] lfsr_q;
    logic       lfsr_unused;

    ysyx_25030081_lfsr8 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (req_fire),
        .state (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[7:3];
    assign cnt_load    = CNT_W'(LATENCY) + {{(CNT_W-3){1'b0}}, lfsr_q[2:0]};
`else
    assign cnt_load    = CNT_W'(LATENCY);
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and handshake outputs; ready and valid are decoded from
    // disjoint states so they can never overlap.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Delay counter and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (req_fire) begin
                cnt_q <= cnt_load;
            end else if (state_q == ST_BUSY) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (access) begin
                rsp_err   <= addr_err;
                rsp_rdata <= (!addr_err && !lat_wen) ? mem[word_idx] : '0;
            end
        end
    end

    // Request capture: inputs are only looked at on the handshake.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            lat_wen   <= req_wen;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wmask <= req_wmask;
        end
    end

    // Byte-lane array write. A reset during BUSY forces state_q to IDLE,
    // which suppresses a write that has not yet happened.
    always_ff @(posedge clk) begin
        if (access && lat_wen && !addr_err) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (lat_wmask[i]) begin
                    mem[word_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25030081_sram_resp.sv
module tb_ysyx_25030081_sram_resp;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_wen;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    ysyx_25030081_sram_resp #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive a request, let it handshake, then scramble
    // the request inputs to show they are ignored afterwards.
    task automatic issue(input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wmask);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wen   = ~wen;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wmask = 4'($urandom);
    endtask

    // Counts rising edges after the request handshake until rsp_valid is seen.
    task automatic wait_rsp(input string tag, output int lat);
        bit ok;
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_rsp_seen"}, 32'(ok), 32'd1);
`ifdef YSYX_25030081_SRAM_RAND_DELAY_EN
        check({tag, "_lat_range"}, 32'(lat >= LAT && lat <= LAT + 7), 32'd1);
`else
        check({tag, "_lat"}, 32'(lat), 32'(LAT));
`endif
    endtask

    // Compare the response against the scoreboard head and complete it.
    task automatic finish_rsp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        check({tag, "_rdata"}, rsp_rdata, e.rdata);
        check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
        check({tag, "_no_overlap"}, 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    task automatic txn(input string tag, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wmask,
                       input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        check({tag, "_ready_pre"}, 32'(req_ready), 32'd1);
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        issue(wen, addr, wdata, wmask);
        wait_rsp(tag, lat);
        finish_rsp(tag);
    endtask

    initial begin
        int   lat;
        exp_t e;
        logic [31:0] held;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_valid", 32'(rsp_valid), 32'd0);
        check("idle_rdata", rsp_rdata, 32'h0);
        check("idle_err", 32'(rsp_err), 32'd0);

        // Full-word write then read-back
        txn("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        txn("rd10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Byte-lane writes
        txn("wr10_b0", 1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 1'b0);
        txn("wr10_b2", 1'b1, 32'h10, 32'h00CC0000, 4'b0100, 32'h0, 1'b0);
        txn("rd10_lanes", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDECCBEAA, 1'b0);

        // Empty mask is a no-op without error
        txn("wr10_nomask", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
        txn("rd10_nomask", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDECCBEAA, 1'b0);

        // Misaligned and out-of-range accesses
        txn("rd13_mis", 1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1);
        txn("wr0", 1'b1, 32'h0, 32'h12345678, 4'hF, 32'h0, 1'b0);
        txn("wr_oob", 1'b1, 32'(4 * DEPTH), 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        txn("rd0_after_oob", 1'b0, 32'h0, 32'h0, 4'h0, 32'h12345678, 1'b0);
        txn("rd_last", 1'b1, 32'(4 * DEPTH - 4), 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        txn("rd_last_back", 1'b0, 32'(4 * DEPTH - 4), 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);

        // Backpressure: hold the response while a new request waits
        check("bp_ready_pre", 32'(req_ready), 32'd1);
        sb.push_back('{rdata: 32'hDECCBEAA, err: 1'b0});
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        wait_rsp("bp", lat);
        held = rsp_rdata;
        check("bp_rdata", held, sb[0].rdata);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'hA5A55A5A;
        req_wmask = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_rdata", rsp_rdata, held);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        e = sb.pop_front();
        check("bp_err", 32'(rsp_err), 32'(e.err));
        sb.push_back('{rdata: 32'h0, err: 1'b0});
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_valid_drop", 32'(rsp_valid), 32'd0);
        check("bp_ready_next", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'h40;
        wait_rsp("bp_wr30", lat);
        finish_rsp("bp_wr30");
        txn("rd30", 1'b0, 32'h30, 32'h0, 4'h0, 32'hA5A55A5A, 1'b0);

        // Reset while a write is pending
        txn("wr20", 1'b1, 32'h20, 32'h11111111, 4'hF, 32'h0, 1'b0);
        issue(1'b1, 32'h20, 32'h22222222, 4'hF);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_rst_quiet", 32'(rsp_valid), 32'd0);
        txn("rd20_after_rst", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11111111, 1'b0);

        // Repeated requests; with random delay enabled this sweeps latencies
`ifdef YSYX_25030081_SRAM_RAND_DELAY_EN
        for (int i = 0; i < 50; i++) begin
`else
        for (int i = 0; i < 4; i++) begin
`endif
            txn("rep_rd", 1'b0, 32'h30, 32'h0, 4'h0, 32'hA5A55A5A, 1'b0);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/ysyx_25030081_sram_resp.md
Name: ysyx_25030081_sram_resp

Overview:
- Memory-side responder for the core's load/store unit: the target end of the data-memory interface the LSU drives.
- Accepts one word-aligned read or write request per transaction over a valid/ready request channel, holding the next request off while busy.
- Performs the access on an internal word array after a fixed, parameterized latency.
- Returns read data and an error flag on a valid/ready response channel.
- Replaces the zero-latency DPI pmem path when the core is run against a timed memory.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, word width; fixed at 32 (4 byte lanes)
DEPTH, 1024, number of words in the array
LATENCY, 2, cycles from request handshake to rsp_valid; legal range 1..15

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_wen  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  write data, lane-aligned
req_wmask  in  4  byte-lane write enable; bit i selects byte i
rsp_valid  out  1  response present
rsp_ready  in  1  initiator accepts the response
rsp_rdata  out  DATA_WIDTH  read word; 0 for writes and for errors
rsp_err  out  1  address out of range or misaligned

Behaviour:
- Reset is asynchronous and active-high; one clock domain (clk).
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, delay counter=0.
- Array contents are not reset.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch wen/addr/wdata/wmask, load counter=LATENCY, go to BUSY.
  - BUSY: req_ready=0. Decrement the counter each cycle. At counter==1, perform the access, register rsp_rdata/rsp_err, go to RESP.
  - RESP: rsp_valid=1, req_ready=0. rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready, then go to IDLE and drop rsp_valid.
- Latency:
  - Request handshake in cycle N gives rsp_valid high from cycle N+LATENCY.
  - Response handshake in cycle M gives req_ready high in cycle M+1.
  - req_ready is never asserted in the same cycle as rsp_valid; there is no overlap.
- Address decode:
  - Word index = req_addr[log2(DEPTH)+1:2].
  - err = (req_addr[1:0]!=0) || (req_addr>>2 >= DEPTH).
- Error: no array update, rsp_rdata=0, rsp_err=1.
- Write:
  - For each i where wmask[i]=1, mem[idx][8i+7:8i] <= wdata[8i+7:8i]. All other bytes are unchanged.
  - wmask=0 is a legal no-op with err=0.
  - rsp_rdata=0.
- Read: rsp_rdata = full word mem[idx]. The initiator performs lane extraction and sign or zero extension.
- Request inputs are sampled only at the handshake. Changes while BUSY or RESP are ignored.
- rsp_valid with rsp_ready low holds indefinitely with no data change.
- Reset asserted in BUSY or RESP:
  - Immediately return to IDLE and clear rsp_valid.
  - A pending write not yet performed is dropped; one already performed stays.
- A read and a write to the same word in consecutive transactions: the read sees the written data, because accesses are strictly serialized.

Optional Feature:
- Macro: YSYX_25030081_SRAM_RAND_DELAY_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seeded 8'hA5 on reset, steps on each request handshake.
  - Its low 3 bits are added to the counter load, so response latency is LATENCY..LATENCY+7 cycles.
- Undefined: latency is exactly LATENCY and no LFSR logic exists.

Decomposition:
- Shared package/header ysyx_25030081_mem_pkg:
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2).
  - Byte-mask width constant (4).
  - LFSR seed and tap constants.
- One sub-module, ysyx_25030081_lfsr8: enable, state output, asynchronous reset to seed. Instantiated only under the macro.

Test Plan:
- Reset then idle: after rst deasserts, req_ready=1, rsp_valid=0, rsp_rdata=0.
- Write then read back:
  - Write addr 0x10, wdata 0xDEADBEEF, wmask 4'hF, LATENCY=2; handshake in cycle N gives rsp_valid in N+2, rsp_err=0.
  - Read of 0x10 returns 0xDEADBEEF.
- Byte-lane write: write 0x000000AA with mask 4'b0001 and then 0x00CC0000 with mask 4'b0100 to 0x10 holding 0xDEADBEEF; a read returns 0xDECCBEAA.
- Errors:
  - Read 0x13 gives rsp_err=1, rsp_rdata=0.
  - Write to byte address 4*DEPTH gives rsp_err=1, and a readback of word 0 is unchanged.
- Backpressure: rsp_ready held low 5 cycles gives rsp_valid and rsp_rdata stable throughout, req_ready=0, and a new req_valid is not accepted until the cycle after the response handshake.
- Reset mid-op: rst in BUSY during a write to 0x20 (old value 0x11111111) gives rsp_valid=0 and state IDLE; a readback of 0x20 returns 0x11111111. With the macro defined, latencies observed across 50 requests all lie in [LATENCY, LATENCY+7].
